// File: rtl/jk_bank_scheduler.sv
// jk_bank_scheduler: round-robin scheduler sharing one bank of N JK flip-flops between requesters A and B
// Ports:
//   clk, reset                 clock (rising edge), asynchronous active-high reset
//   a_valid/a_ready/a_op/a_idx/a_cnt   requester A command handshake: {j,k} op, target bit, toggle count
//   b_valid/b_ready/b_op/b_idx/b_cnt   requester B, same as A
//   j_vec, k_vec               registered single-cycle pulses to the bank j/k inputs
//   q_vec                      bank q outputs read back on completion
//   busy                       high whenever not IDLE
//   done, done_src, done_q, done_err   completion pulse, requester (0=A,1=B), resulting q, bad-index flag
module jk_bank_scheduler #(
    parameter int N    = 8,
    parameter int IDXW = 3,
    parameter int CNTW = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            a_valid,
    output logic            a_ready,
    input  logic [1:0]      a_op,
    input  logic [IDXW-1:0] a_idx,
    input  logic [CNTW-1:0] a_cnt,
    input  logic            b_valid,
    output logic            b_ready,
    input  logic [1:0]      b_op,
    input  logic [IDXW-1:0] b_idx,
    input  logic [CNTW-1:0] b_cnt,
    output logic [N-1:0]    j_vec,
    output logic [N-1:0]    k_vec,
    input  logic [N-1:0]    q_vec,
    output logic            busy,
    output logic            done,
    output logic            done_src,
    output logic            done_q,
    output logic            done_err
);
    typedef enum logic [1:0] {IDLE, PULSE, SETTLE, DONE} state_t;
    localparam logic [N-1:0] ONE = N'(1);
    state_t          state;
    logic            rr_ptr;
    logic            src;
    logic [1:0]      op;
    logic [IDXW-1:0] idx;
    logic [CNTW-1:0] rem;
    logic [1:0]      g_op;
    logic [IDXW-1:0] g_idx;
    logic [CNTW-1:0] g_cnt;
    logic [N-1:0]    g_sel;
    logic [N-1:0]    sel;
    logic [N-1:0]    q_sh;
    logic            g_err;
    assign busy    = state != IDLE;
    // reset gating keeps both ready low while reset is held, even though state already reads IDLE
    assign a_ready = ~reset & (state == IDLE) & a_valid & (~b_valid | ~rr_ptr);
    assign b_ready = ~reset & (state == IDLE) & b_valid & (~a_valid | rr_ptr);
    always_comb begin
        g_op  = b_ready ? b_op : a_op;
        g_idx = b_ready ? b_idx : a_idx;
        g_cnt = b_ready ? b_cnt : a_cnt;
        g_sel = ONE << g_idx;
        g_err = int'(g_idx) >= N;
        sel   = ONE << idx;
        q_sh  = q_vec >> idx;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            rr_ptr   <= 1'b0;
            src      <= 1'b0;
            op       <= '0;
            idx      <= '0;
            rem      <= '0;
            j_vec    <= '0;
            k_vec    <= '0;
            done     <= 1'b0;
            done_src <= 1'b0;
            done_q   <= 1'b0;
            done_err <= 1'b0;
        end else begin
            done  <= 1'b0;
            j_vec <= '0;
            k_vec <= '0;
            case (state)
                IDLE: if (a_ready | b_ready) begin
                    op     <= g_op;
                    idx    <= g_idx;
                    rem    <= (g_cnt == '0) ? CNTW'(1) : g_cnt;
                    src    <= b_ready;
                    rr_ptr <= a_ready;
                    if (g_err) begin
                        // out-of-range index: report immediately without touching the bank
                        state    <= DONE;
                        done     <= 1'b1;
                        done_src <= b_ready;
                        done_q   <= 1'b0;
                        done_err <= 1'b1;
                    end else begin
                        state <= PULSE;
                        j_vec <= g_op[1] ? g_sel : '0;
                        k_vec <= g_op[0] ? g_sel : '0;
                    end
                end
                PULSE: state <= SETTLE;
                SETTLE: if (op == 2'b11 && rem > CNTW'(1)) begin
                    rem   <= rem - CNTW'(1);
                    state <= PULSE;
                    j_vec <= sel;
                    k_vec <= sel;
                end else begin
                    state    <= DONE;
                    done     <= 1'b1;
                    done_src <= src;
                    done_q   <= q_sh[0];
                    done_err <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
